keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- 4x4 matrix keypad scanner and debouncer.
- Sits directly downstream of the per-row synchronizer: it consumes the four synchronized row lines and drives the keypad columns.
- Emits a one-cycle key_valid strobe with a 4-bit key code per debounced press, plus a level key_held while the key stays down.
- Only one key is tracked at a time; further presses are ignored until release.

Parameters:
- SETTLE_CYCLES, default 4: cycles each column is driven before rows are sampled; must be at least 3 to cover 2 synchronizer flops plus pad settling.
- DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required to accept a press or a release; must be at least 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rows_sync  input  4  synchronized row lines, active-low (0 = key in that row pressed on the driven column)
- cols  output  4  column drive, active-low, exactly one bit low at all times
- key_valid  output  1  one-cycle strobe on each accepted press
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key; holds its value between presses
- key_held  output  1  high from the key_valid cycle until the release is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=SCAN, col_idx=0, cols=4'b1110, settle and debounce counters=0, key_valid=0, key_code=0, key_held=0.
- Column drive: cols = ~(4'b0001 << col_idx), registered.
- Row selection: row_idx = index of the lowest-numbered 0 bit in rows_sync. The pattern is captured whole.
- SCAN:
  - Settle counter counts 0..SETTLE_CYCLES-1.
  - On the last count, if rows_sync==4'b1111: col_idx increments mod 4 (3 wraps to 0), counter clears, stay in SCAN.
  - Otherwise: capture pattern and row_idx, clear debounce counter, go to DEBOUNCE with col_idx unchanged.
- DEBOUNCE:
  - Each cycle rows_sync==captured pattern, the counter increments.
  - Any mismatch, including release or a second key: go to SCAN, col_idx+1, no strobe.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a match: on that edge go to HELD, key_valid=1, key_code={row_idx,col_idx}, key_held=1.
  - Latency: key_valid rises exactly DEBOUNCE_CYCLES cycles after the SCAN sampling edge.
- HELD:
  - key_valid=0 after its single cycle.
  - The column stays driven and the counter clears.
  - Counter increments each cycle rows_sync==4'b1111 and clears on any 0.
  - At DEBOUNCE_CYCLES-1: key_held=0, go to SCAN with col_idx+1 and settle counter 0.
  - A pattern change while still pressed (extra key, bounce) restarts the release count only; no new strobe.
- key_valid is never high on two consecutive cycles.
- A press is never reported twice without an accepted release in between.
- Reset asserted mid-operation returns all state to reset values immediately; a key already down is re-detected by a normal scan after reset is released.
- Counter widths sized from the parameters with $clog2; no overflow is possible.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=4):
1. Idle: rows_sync=4'b1111 for 40 cycles after reset release -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid=0 throughout.
2. Clean press: row 2 held low only while col 1 is driven, for 30 cycles -> exactly one key_valid pulse 4 cycles after the sampling edge; key_code=4'b1001; key_held=1 until 4 cycles after rows return to 1111; cols then moves to 1011.
3. Bounce: row 0 low for 2 cycles, high for 1, then low steadily, on col 3 -> first attempt aborts with no strobe; the press is accepted on the next pass of col 3 with key_code=4'b0011 and a single pulse.
4. Release bounce: in HELD, rows toggle 1111/1110 every 2 cycles for 12 cycles, then stay 1111 -> key_held stays 1 during toggling and falls 4 cycles after the stable release; no extra key_valid.
5. Multiple rows: rows_sync=4'b0110 on col 0 -> key_code=4'b0000 (lowest row wins); one pulse only.
6. Reset mid-debounce: reset=0 for 1 cycle during DEBOUNCE -> cols=1110, key_valid=0, key_held=0, key_code=0 immediately; scanning restarts from col 0 after reset is released.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
// Drives one column low at a time, debounces a single key and strobes its code.
module keypad_scanner #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_sync,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [1:0]    col_next;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] db_cnt;
    logic [3:0]    pattern;
    logic [1:0]    row_idx;
    logic [1:0]    row_first;
    logic [3:0]    cols_next;

    assign col_next  = col_idx + 2'd1;
    assign cols_next = ~(4'b0001 << col_next);

    // Lowest-numbered active (low) row wins when several rows are down.
    always_comb begin
        row_first = 2'd3;
        if (!rows_sync[0])      row_first = 2'd0;
        else if (!rows_sync[1]) row_first = 2'd1;
        else if (!rows_sync[2]) row_first = 2'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_SCAN;
            col_idx    <= 2'd0;
            cols       <= 4'b1110;
            settle_cnt <= '0;
            db_cnt     <= '0;
            pattern    <= 4'hF;
            row_idx    <= 2'd0;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
            key_held   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        if (rows_sync == 4'hF) begin
                            col_idx <= col_next;
                            cols    <= cols_next;
                        end else begin
                            pattern <= rows_sync;
                            row_idx <= row_first;
                            db_cnt  <= '0;
                            state   <= ST_DEBOUNCE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_sync != pattern) begin
                        state      <= ST_SCAN;
                        col_idx    <= col_next;
                        cols       <= cols_next;
                        settle_cnt <= '0;
                    end else if (db_cnt == DEBOUNCE_LAST) begin
                        state     <= ST_HELD;
                        key_valid <= 1'b1;
                        key_code  <= {row_idx, col_idx};
                        key_held  <= 1'b1;
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                ST_HELD: begin
                    // Any low row, even a different key, restarts the release count.
                    if (rows_sync != 4'hF) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DEBOUNCE_LAST) begin
                        key_held   <= 1'b0;
                        state      <= ST_SCAN;
                        col_idx    <= col_next;
                        cols       <= cols_next;
                        settle_cnt <= '0;
                        db_cnt     <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: begin
                    state      <= ST_SCAN;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
// Emulates a physical key matrix driven by the scanner's column outputs.
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows_sync;
    logic [3:0]  cols;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c is down
    logic        prev_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        rows_sync = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows_sync[r] = 1'b0;
    end

    keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .rows_sync(rows_sync), .cols(cols),
        .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
    );

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ($countones(~cols) != 1) begin
                failures++;
                $display("FAIL cols_one_low got=%b exp=exactly one zero", cols);
            end
            checks++;
            if (key_valid && prev_valid) begin
                failures++;
                $display("FAIL valid_back_to_back got=1,1 exp=single cycle");
            end
            prev_valid = key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        keys = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        keys = '0;
        tick();
        tick();
        checks++; if (cols !== 4'b1110) begin failures++; $display("FAIL reset_cols got=%b exp=1110", cols); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%b exp=0000", key_code); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            checks++;
            if (cols !== col_pat((n / S) % 4)) begin
                failures++; $display("FAIL idle_cols n=%0d got=%b exp=%b", n, cols, col_pat((n / S) % 4));
            end
            checks++;
            if (key_valid !== 1'b0) begin failures++; $display("FAIL idle_valid n=%0d got=%b exp=0", n, key_valid); end
        end
    endtask

    task automatic test_clean_press();
        int strobe_n;
        int rel_n;
        strobe_n = S * 2 + D;
        rel_n = 30;
        apply_reset();
        keys[2*4+1] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == rel_n) keys = '0;
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL press_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            checks++;
            if (key_held !== (n >= strobe_n && n < rel_n + D)) begin
                failures++; $display("FAIL press_held n=%0d got=%b exp=%b", n, key_held, n >= strobe_n && n < rel_n + D);
            end
            if (n >= strobe_n) begin
                checks++;
                if (key_code !== 4'b1001) begin failures++; $display("FAIL press_code n=%0d got=%b exp=1001", n, key_code); end
            end
            if (n == rel_n + D) begin
                checks++;
                if (cols !== 4'b1011) begin failures++; $display("FAIL press_next_col got=%b exp=1011", cols); end
            end
        end
    endtask

    task automatic test_bounce();
        int abort_n;
        int strobe_n;
        abort_n = 4 * S + 2;
        strobe_n = abort_n + 3 * S + S + D;
        apply_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 4 * S - 1) keys[3] = 1'b1;
            if (n == 4 * S + 1) keys[3] = 1'b0;
            if (n == abort_n)   keys[3] = 1'b1;
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL bounce_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            if (n == abort_n) begin
                checks++;
                if (cols !== 4'b1110) begin failures++; $display("FAIL bounce_abort_cols got=%b exp=1110", cols); end
            end
            if (n >= strobe_n) begin
                checks++;
                if (key_code !== 4'b0011) begin failures++; $display("FAIL bounce_code n=%0d got=%b exp=0011", n, key_code); end
            end
        end
    endtask

    task automatic test_release_bounce();
        int strobe_n;
        strobe_n = S + D;
        apply_reset();
        keys[0] = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (n >= 10 && n <= 22) keys[0] = (((n - 10) / 2) % 2) == 1;
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL relb_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            checks++;
            if (key_held !== (n >= strobe_n && n < 22 + D)) begin
                failures++; $display("FAIL relb_held n=%0d got=%b exp=%b", n, key_held, n >= strobe_n && n < 22 + D);
            end
        end
    endtask

    task automatic test_multi_row();
        int strobe_n;
        strobe_n = S + D;
        apply_reset();
        keys[0*4+0] = 1'b1;
        keys[3*4+0] = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            tick();
            if (n == 20) keys = '0;
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL multi_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            checks++;
            if (key_held !== (n >= strobe_n && n < 20 + D)) begin failures++; $display("FAIL multi_held n=%0d got=%b", n, key_held); end
            if (n >= strobe_n) begin
                checks++;
                if (key_code !== 4'b0000) begin failures++; $display("FAIL multi_code n=%0d got=%b exp=0000", n, key_code); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int strobe_n;
        strobe_n = 3 * S + D;
        apply_reset();
        keys[1*4+2] = 1'b1;
        for (int n = 1; n <= 29; n++) begin
            tick();
            if (n == 20) keys = '0;
            if (n == 24) keys[2*4+3] = 1'b1;
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL mid_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            if (n >= strobe_n) begin
                checks++;
                if (key_code !== 4'b0110) begin failures++; $display("FAIL mid_code n=%0d got=%b exp=0110", n, key_code); end
            end
        end
        reset = 1'b0;
        #1;
        checks++; if (cols !== 4'b1110) begin failures++; $display("FAIL async_cols got=%b exp=1110", cols); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL async_held got=%b exp=0", key_held); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL async_code got=%b exp=0000", key_code); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        strobe_n = 4 * S + D;
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (n < 4 * S) begin
                checks++;
                if (cols !== col_pat((n / S) % 4)) begin failures++; $display("FAIL rescan_cols n=%0d got=%b exp=%b", n, cols, col_pat((n / S) % 4)); end
            end
            checks++;
            if (key_valid !== (n == strobe_n)) begin failures++; $display("FAIL rescan_valid n=%0d got=%b exp=%b", n, key_valid, n == strobe_n); end
            if (n >= strobe_n) begin
                checks++;
                if (key_code !== 4'b1011) begin failures++; $display("FAIL rescan_code n=%0d got=%b exp=1011", n, key_code); end
            end
        end
    endtask

    task automatic test_random();
        int c;
        int hold;
        int pulses;
        int pulse_n;
        logic [3:0] mask;
        logic [1:0] row;
        logic [3:0] exp_code;
        apply_reset();
        for (int it = 0; it < 20; it++) begin
            c = $urandom_range(0, 3);
            mask = 4'($urandom_range(1, 15));
            row = 2'd0;
            for (int r = 3; r >= 0; r--) if (mask[r]) row = 2'(r);
            exp_code = {row, 2'(c)};
            repeat ($urandom_range(0, 9)) begin
                tick();
                checks++;
                if (key_valid !== 1'b0) begin failures++; $display("FAIL rnd_idle_valid it=%0d got=%b exp=0", it, key_valid); end
            end
            for (int r = 0; r < 4; r++) keys[r*4+c] = mask[r];
            hold = $urandom_range(30, 50);
            pulses = 0;
            pulse_n = -1;
            for (int n = 1; n <= hold; n++) begin
                tick();
                if (pulse_n > 0) begin
                    checks++;
                    if (key_held !== 1'b1) begin failures++; $display("FAIL rnd_held it=%0d n=%0d got=%b exp=1", it, n, key_held); end
                end
                if (key_valid) begin
                    pulses++;
                    pulse_n = n;
                    checks++;
                    if (key_code !== exp_code) begin failures++; $display("FAIL rnd_code it=%0d got=%b exp=%b", it, key_code, exp_code); end
                end else if (pulse_n < 0) begin
                    checks++;
                    if (key_held !== 1'b0) begin failures++; $display("FAIL rnd_early_held it=%0d n=%0d got=%b exp=0", it, n, key_held); end
                end
            end
            checks++;
            if (pulses != 1) begin failures++; $display("FAIL rnd_pulses it=%0d got=%0d exp=1", it, pulses); end
            checks++;
            if (pulse_n > 5 * S + D + 1) begin failures++; $display("FAIL rnd_latency it=%0d got=%0d exp<=%0d", it, pulse_n, 5 * S + D + 1); end
            keys = '0;
            for (int n = 1; n <= D; n++) begin
                tick();
                checks++;
                if (key_valid !== 1'b0) begin failures++; $display("FAIL rnd_rel_valid it=%0d got=%b exp=0", it, key_valid); end
                checks++;
                if (key_held !== (n < D)) begin failures++; $display("FAIL rnd_rel_held it=%0d n=%0d got=%b exp=%b", it, n, key_held, n < D); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_multi_row();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
